// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a BYTES-wide word as back-to-back UART frames, LSB byte first.
// Frame: start, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Optional feature macro: UART_WORD_TX_PARITY_EN (adds an even-parity bit per frame).
module uart_word_tx #(
    parameter int unsigned CLKS_PER_BIT = 5,
    parameter int unsigned BYTES        = 2,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*BYTES-1:0]   i_data,
    input  logic                 wr,
    output logic                 busy,
    output logic                 done,
    output logic                 s_out
);

    localparam int unsigned WORD_W = 8 * BYTES;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_WORD_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          bit_idx;
    logic [BYTE_W-1:0]   byte_idx;
    logic                stop_idx;
    logic [WORD_W-1:0]   shreg;
    logic [7:0]          cur_byte;
    logic                cnt_last_c;

    // Current byte is always the low byte of the word shift register.
    assign cur_byte   = shreg[7:0];
    assign cnt_last_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Frame sequencer with registered line, busy and done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            s_out    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    s_out <= 1'b1;
                    busy  <= 1'b0;
                    if (wr) begin
                        shreg    <= i_data;
                        byte_idx <= '0;
                        cnt      <= '0;
                        state    <= S_START;
                        s_out    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_last_c) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        s_out   <= cur_byte[0];
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                S_DATA: begin
                    if (cnt_last_c) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
                            state <= S_PARITY;
                            s_out <= ^cur_byte;
`else
                            state    <= S_STOP;
                            s_out    <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            bit_idx <= 3'(bit_idx + 3'd1);
                            s_out   <= cur_byte[3'(bit_idx + 3'd1)];
                        end
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
`ifdef UART_WORD_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt_last_c) begin
                        cnt      <= '0;
                        state    <= S_STOP;
                        s_out    <= 1'b1;
                        stop_idx <= 1'b0;
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_last_c) begin
                        cnt <= '0;
                        if (stop_idx != 1'(STOP_BITS - 1)) begin
                            stop_idx <= 1'b1;
                        end else if (byte_idx < BYTE_W'(BYTES - 1)) begin
                            // Next byte follows immediately with no idle gap.
                            byte_idx <= BYTE_W'(byte_idx + 1'b1);
                            shreg    <= shreg >> 8;
                            state    <= S_START;
                            s_out    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            s_out <= 1'b1;
                        end
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    s_out <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed testbench for uart_word_tx: three instances cover the default
// configuration, two stop bits, and a single-byte word.
module tb_uart_word_tx;

    localparam int C = 5;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_a, wr_b, wr_c;
    logic [15:0] data_a, data_b;
    logic [7:0]  data_c;
    logic        busy_a, done_a, s_a;
    logic        busy_b, done_b, s_b;
    logic        busy_c, done_c, s_c;

    int total;
    int passed;

    uart_word_tx #(.CLKS_PER_BIT(5), .BYTES(2), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(data_a), .wr(wr_a),
        .busy(busy_a), .done(done_a), .s_out(s_a));

    uart_word_tx #(.CLKS_PER_BIT(5), .BYTES(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(data_b), .wr(wr_b),
        .busy(busy_b), .done(done_b), .s_out(s_b));

    uart_word_tx #(.CLKS_PER_BIT(5), .BYTES(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_data(data_c), .wr(wr_c),
        .busy(busy_c), .done(done_c), .s_out(s_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {s_out, busy, done} of the selected instance
    function automatic logic [2:0] obs(input int which);
        case (which)
            0:       return {s_a, busy_a, done_a};
            1:       return {s_b, busy_b, done_b};
            default: return {s_c, busy_c, done_c};
        endcase
    endfunction

    task automatic set_wr(input int which, input logic v, input logic [15:0] d);
        case (which)
            0:       begin wr_a = v; data_a = d; end
            1:       begin wr_b = v; data_b = d; end
            default: begin wr_c = v; data_c = d[7:0]; end
        endcase
    endtask

    // Expected line level at cycle k (1-based) of a word with frame length f_len bits.
    function automatic logic line_bit(input logic [63:0] word, input int k, input int f_len);
        int b, f, p;
        logic [63:0] sh;
        logic [7:0] by;
        b  = (k - 1) / C;
        f  = b / f_len;
        p  = b % f_len;
        sh = word >> (8 * f);
        by = sh[7:0];
        if (p == 0) return 1'b0;
        if (p <= 8) return by[p-1];
        if (p == 9 && PAR == 1) return ^by;
        return 1'b1;
    endfunction

    // Start a word: wr sampled at the next rising edge.
    task automatic start_word(input int which, input logic [15:0] d, input bit hold);
        set_wr(which, 1'b1, d);
        @(posedge clk);
        #1;
        if (!hold) set_wr(which, 1'b0, d);
    endtask

    // Check cycles 1..D+1 of a word. poke=1 pulses wr with 16'hFFFF mid-word,
    // poke=2 drops a held wr early in the word.
    task automatic check_word(input int which, input logic [63:0] word, input int bytes,
                              input int stop, input string name, input int poke);
        int f_len, d;
        logic [2:0] o, e;
        f_len = 1 + 8 + PAR + stop;
        d     = bytes * f_len * C;
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            o = obs(which);
            e = {(k > d) ? 1'b1 : line_bit(word, k, f_len), (k <= d), (k == d + 1)};
            total++;
            if (o !== e)
                $display("FAIL %s cycle %0d: {s_out,busy,done} got %b expected %b", name, k, o, e);
            else
                passed++;
            if (poke == 1 && k == 20) set_wr(which, 1'b1, 16'hFFFF);
            if (poke == 1 && k == 40) set_wr(which, 1'b0, 16'hFFFF);
            if (poke == 2 && k == 3)  set_wr(which, 1'b0, 16'h0000);
        end
    endtask

    task automatic check_idle(input int which, input int n, input string name);
        logic [2:0] o;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            o = obs(which);
            total++;
            if (o !== 3'b100)
                $display("FAIL %s cycle %0d: {s_out,busy,done} got %b expected 100", name, k, o);
            else
                passed++;
        end
    endtask

    task automatic test_reset();
        logic [2:0] o;
        rst_n = 1'b0;
        set_wr(0, 1'b0, 16'h0);
        set_wr(1, 1'b0, 16'h0);
        set_wr(2, 1'b0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            o = obs(w);
            total++;
            if (o !== 3'b100)
                $display("FAIL reset_hold dut%0d: got %b expected 100", w, o);
            else
                passed++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int w = 0; w < 3; w++) begin
                o = obs(w);
                total++;
                if (o !== 3'b100)
                    $display("FAIL reset_idle dut%0d cycle %0d: got %b expected 100", w, k, o);
                else
                    passed++;
            end
        end
    endtask

    task automatic test_two_byte_word();
        start_word(0, 16'hA55A, 1'b0);
        check_word(0, 64'hA55A, 2, 1, "word_A55A", 0);
        check_idle(0, 3, "after_A55A");
    endtask

    task automatic test_single_byte();
        start_word(2, 16'h0001, 1'b0);
        check_word(2, 64'h01, 1, 1, "byte_01", 0);
        check_idle(2, 3, "after_01");
        start_word(2, 16'h00C3, 1'b0);
        check_word(2, 64'hC3, 1, 1, "byte_C3", 0);
    endtask

    task automatic test_busy_ignore();
        start_word(0, 16'hA55A, 1'b0);
        check_word(0, 64'hA55A, 2, 1, "busy_ignore", 1);
        check_idle(0, 20, "no_second_word");
    endtask

    task automatic test_reset_midframe();
        logic [2:0] o;
        start_word(0, 16'hA55A, 1'b0);
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        o = obs(0);
        total++;
        if (o !== 3'b100)
            $display("FAIL reset_midframe: got %b expected 100", o);
        else
            passed++;
        rst_n = 1'b1;
        check_idle(0, 2, "post_reset_idle");
        start_word(0, 16'h3C81, 1'b0);
        check_word(0, 64'h3C81, 2, 1, "after_reset_3C81", 0);
    endtask

    task automatic test_back_to_back();
        start_word(1, 16'h12F0, 1'b1);
        check_word(1, 64'h12F0, 2, 2, "b2b_word1", 0);
        check_word(1, 64'h12F0, 2, 2, "b2b_word2", 2);
        check_idle(1, 5, "b2b_end");
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_two_byte_word();
        test_single_byte();
        test_busy_ignore();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
